// File: rtl/arb_pkg.sv
// Shared definitions for the two-requester bus arbiter: state encoding,
// default word width and the width helper for the burst beat counter.
package arb_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

  // Width of a counter holding 0..max_burst-1, never narrower than one bit.
  function automatic int cnt_w(input int max_burst);
    return (clog2(max_burst) < 1) ? 1 : clog2(max_burst);
  endfunction

endpackage

// File: rtl/mux_bus_arbiter_if.sv
// Bundle of requester, select/grant and output-stage signals for the arbiter.
//
// Handshake: a beat moves across a channel on a rising clock edge where both
// valid and ready are high. ready is never derived from the same channel's
// valid; the producer holds valid, data and last stable until it sees ready.
interface mux_bus_arbiter_if
  import arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              req0_valid;
  logic [DATA_W-1:0] req0_data;
  logic              req0_last;
  logic              req0_ready;
  logic              req1_valid;
  logic [DATA_W-1:0] req1_data;
  logic              req1_last;
  logic              req1_ready;
  logic              select;
  logic [1:0]        grant_id;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  // Producers and the downstream consumer.
  modport master (
    output req0_valid, req0_data, req0_last,
    output req1_valid, req1_data, req1_last,
    output out_ready,
    input  req0_ready, req1_ready, select, grant_id, out_valid, out_data
  );

  // The arbiter itself.
  modport slave (
    input  req0_valid, req0_data, req0_last,
    input  req1_valid, req1_data, req1_last,
    input  out_ready,
    output req0_ready, req1_ready, select, grant_id, out_valid, out_data
  );

endinterface

// File: rtl/mux_2_1.sv
// Plain 2:1 datapath mux shared by the two producers.
module mux_2_1 #(
  parameter int WIDTH = 32
) (
  input  logic             select,
  input  logic [WIDTH-1:0] input0,
  input  logic [WIDTH-1:0] input1,
  output logic [WIDTH-1:0] out
);

  // select = 0 passes input0, select = 1 passes input1.
  assign out = select ? input1 : input0;

endmodule

// File: rtl/mux_bus_arbiter.sv
// Round-robin arbiter/sequencer for two bursting requesters sharing one 2:1
// mux, with a single registered valid/ready output stage. Grants are held for
// a whole burst (up to MAX_BURST beats) and handed over without a bubble.
module mux_bus_arbiter
  import arb_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  mux_bus_arbiter_if.slave bus,
  output state_t     dbg_state
);

  localparam int               CNT_W     = cnt_w(MAX_BURST);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  state_t            state;
  state_t            state_nxt;
  logic              rr_ptr;
  logic [CNT_W-1:0]  beat_cnt;
  logic              sel_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [DATA_W-1:0] mux_out;

  logic              drain_ok;
  logic              ready0;
  logic              ready1;
  logic              accept;
  logic              release_burst;

  // The select register steers the shared mux; it is updated together with the
  // state so the datapath already points at the new owner on the grant edge.
  mux_2_1 #(
    .WIDTH (DATA_W)
  ) u_mux (
    .select (sel_q),
    .input0 (bus.req0_data),
    .input1 (bus.req1_data),
    .out    (mux_out)
  );

  // Next-state, ready and release decode. Ready depends only on the output
  // stage, so the granted producer can stream one beat per cycle.
  always_comb begin
    state_nxt     = state;
    ready0        = 1'b0;
    ready1        = 1'b0;
    accept        = 1'b0;
    release_burst = 1'b0;
    drain_ok      = !out_valid_q || bus.out_ready;
    case (state)
      IDLE: begin
        if (bus.req0_valid && bus.req1_valid) begin
          state_nxt = rr_ptr ? GRANT1 : GRANT0;
        end else if (bus.req0_valid) begin
          state_nxt = GRANT0;
        end else if (bus.req1_valid) begin
          state_nxt = GRANT1;
        end
      end
      GRANT0: begin
        ready0 = drain_ok;
        accept = bus.req0_valid && drain_ok;
        if (accept && (bus.req0_last || beat_cnt == LAST_BEAT)) begin
          release_burst = 1'b1;
          state_nxt     = bus.req1_valid ? GRANT1 : IDLE;
        end
      end
      GRANT1: begin
        ready1 = drain_ok;
        accept = bus.req1_valid && drain_ok;
        if (accept && (bus.req1_last || beat_cnt == LAST_BEAT)) begin
          release_burst = 1'b1;
          state_nxt     = bus.req0_valid ? GRANT0 : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, round-robin pointer, beat counter and mux select registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= 1'b0;
      beat_cnt <= '0;
      sel_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == GRANT0) begin
        sel_q <= 1'b0;
      end else if (state_nxt == GRANT1) begin
        sel_q <= 1'b1;
      end
      if (release_burst) begin
        rr_ptr   <= (state == GRANT0);
        beat_cnt <= '0;
      end else if (accept) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  // Output stage: load on accept, otherwise empty once the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= mux_out;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.select     = sel_q;
  assign bus.grant_id   = {state == GRANT1, state == GRANT0};
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign dbg_state      = state;

endmodule

// File: doc/mux_bus_arbiter.md
Name: mux_bus_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the shared 32-bit 2:1 datapath mux.
- Grants one requester at a time for a burst of beats and drives the mux select.
- Registers the selected word into a valid/ready output stage.
- Sits between two producers, e.g. ALU result and memory read-back, and the single shared write-back path.

Parameters:
DATA_W, 32, width of each requester word and of the output word
MAX_BURST, 4, maximum beats per grant before forced release (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has a word
req0_data  in  DATA_W  requester 0 word
req0_last  in  1  final beat of requester 0 burst
req0_ready  out  1  requester 0 beat accepted this cycle when high with req0_valid
req1_valid  in  1  requester 1 has a word
req1_data  in  DATA_W  requester 1 word
req1_last  in  1  final beat of requester 1 burst
req1_ready  out  1  requester 1 beat accepted this cycle when high with req1_valid
select  out  1  shared mux select (0 = input0/req0, 1 = input1/req1)
grant_id  out  2  one-hot current grant {g1,g0}; 00 when idle
out_valid  out  1  output word valid
out_data  out  DATA_W  registered selected word
out_ready  in  1  downstream accepts output

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, rr_ptr = 0 (req0 has priority), beat_cnt = 0.
  - Outputs: select = 0, grant_id = 00, out_valid = 0, out_data = 0, req0_ready = req1_ready = 0.
  - Reset asserted mid-burst discards the in-flight output word and the burst with no completion.
- FSM states: IDLE, GRANT0, GRANT1, all registered.
- IDLE:
  - Both requests valid: go to GRANT<rr_ptr>.
  - Only one valid: go to that requester's grant.
  - Neither valid: stay in IDLE.
  - Costs one arbitration cycle; no beat is accepted in IDLE.
- GRANTx:
  - select = x, grant_id one-hot x.
  - reqx_ready = !out_valid || out_ready. This is combinational from out_valid/out_ready, and never from reqx_valid.
  - The other requester's ready = 0.
- Beat accept (reqx_valid && reqx_ready):
  - out_data <= reqx_data, out_valid <= 1 on the next edge. Latency is 1 cycle from accept to out_valid.
  - beat_cnt increments.
- Output stage: out_valid clears when out_ready is high and no new beat is accepted the same cycle. Simultaneous drain and accept keeps out_valid = 1 with the new data (full throughput, 1 beat per cycle).
- Release: a beat is accepted with reqx_last = 1, or with beat_cnt == MAX_BURST-1. On release:
  - rr_ptr <= other.
  - beat_cnt <= 0.
  - Next state = GRANT<other> if the other's valid is high this cycle, else IDLE.
- Back-to-back handover: there is no IDLE bubble, and select switches on the same edge the state changes.
- Granted requester drops valid mid-burst: the grant is held and beat_cnt is unchanged. There is no timeout.
- While idle, select holds its last granted value, so the mux input is stable. grant_id = 00.
- MAX_BURST = 1: every accepted beat releases and the requesters alternate.
- Non-granted valid is ignored. Its data must stay stable until its ready is seen.

Decomposition:
- Shared package (arb_pkg) holds:
  - state encoding constants: IDLE = 2'd0, GRANT0 = 2'd1, GRANT1 = 2'd2
  - DATA_W default
  - clog2 helper for the beat_cnt width
- One sub-module, mux_2_1: the existing 32-bit 2:1 mux. It is instantiated with select driving its select, req0_data/req1_data as input0/input1, and its out feeding the output register.
- The FSM, counter and output register stay in mux_bus_arbiter.

Test Plan:
- Reset then idle:
  - Stimulus: rst_n low 3 cycles, no requests.
  - Required: select = 0, grant_id = 00, out_valid = 0, out_data = 0 throughout.
- Single requester, 2-beat burst:
  - Stimulus: req1 sends 0x0000_0005 then 0x0000_000A with last on the second beat; out_ready = 1.
  - Required: GRANT1 one cycle after valid; out_data 5 then A on consecutive cycles; then IDLE, grant_id = 00.
- Contention, round-robin:
  - Stimulus: both valid continuously with last on every beat; data req0 = 0x11, req1 = 0x22.
  - Required: outputs alternate 0x11, 0x22, 0x11, ...; req0 first after reset; handover has no idle cycle.
- Forced release at MAX_BURST = 4:
  - Stimulus: req0 streams 6 beats with last never asserted; req1 valid.
  - Required: after the 4th accepted beat, grant moves to req1; req0 resumes after req1's burst.
- Backpressure:
  - Stimulus: out_ready = 0 for 5 cycles during a req0 burst.
  - Required: req0_ready = 0 while out_valid = 1; out_data holds its value; no beat is lost or duplicated after out_ready returns.
- Async reset mid-burst:
  - Stimulus: rst_n pulsed low between edges during GRANT1 beat 2.
  - Required: outputs go to reset values immediately without waiting for a clock edge; next arbitration favors req0.
